// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver (uart_rx) and transmitter (uart_tx).
//
// Contents:
//   UART_OVERSAMPLE  - default number of enable ticks per bit period
//   UART_DATA_BITS   - default number of data bits per frame
//   UART_IDLE_LEVEL  - level of an idle serial line (mark = 1)
//   uart_rx_state_e  - receiver state encoding (3 bits, fixed values)
//   uart_mid_tick()  - tick index at which the start bit is sampled
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    // An idle line sits at mark; a start bit is the first space.
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Encoding values are fixed so the state can be read meaningfully from
    // a debug bus or waveform without a lookup table.
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } uart_rx_state_e;

    // The start bit is confirmed half a bit period after the falling edge
    // was seen. Counting starts at 0 on the detecting tick, so the compare
    // value is one less than half the oversample ratio.
    function automatic int uart_mid_tick(input int oversample);
        return (oversample / 2) - 1;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for an asynchronous single-bit input. Both flops reset
// to the idle line level so that a line held idle through reset never looks
// like a start bit when reset is released. Reusable for any asynchronous pin
// whose inactive level is high.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   async_i  in   raw asynchronous input
//   sync_o   out  input re-timed into the clk domain (2 clk latency)
// -----------------------------------------------------------------------------
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= UART_IDLE_LEVEL;
            sync_q <= UART_IDLE_LEVEL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Serial-to-parallel UART receiver: start bit, DATA_BITS data bits sent LSB
// first, one stop bit, no parity, idle-high line. Timing is driven by an
// external oversample tick (enable), OVERSAMPLE ticks per bit period.
//
// Parameters:
//   OVERSAMPLE  enable ticks per bit period (even, >= 4)
//   DATA_BITS   data bits per frame (1..8)
//
// Ports:
//   clk        in   system clock, all state changes on posedge
//   rst_n      in   asynchronous active-low reset
//   enable     in   oversample tick, one clk wide
//   in         in   raw asynchronous serial line
//   data       out  last correctly framed word, bit 0 = first received bit
//   valid      out  one-clk pulse when data has just been updated
//   frame_err  out  one-clk pulse when a stop bit was sampled low
//   busy       out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 in,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(uart_mid_tick(OVERSAMPLE));
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // -------------------------------------------------------------------------
    // Input synchronizer: every decision below looks at rx_s only.
    // -------------------------------------------------------------------------
    logic rx_s;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (in),
        .sync_o  (rx_s)
    );

    // -------------------------------------------------------------------------
    // Receiver state
    // -------------------------------------------------------------------------
    uart_rx_state_e         state_q;
    logic [TICK_W-1:0]      tick_q;
    logic [BIT_W-1:0]       bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   frame_err_q;

    // New samples enter at the top and walk down, so after DATA_BITS samples
    // the first bit on the wire lands in bit 0. A one-bit word has nothing to
    // shift, hence the separate branch.
    generate
        if (DATA_BITS == 1) begin : g_shift_single
            assign shift_d = rx_s;
        end else begin : g_shift_multi
            assign shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RX_IDLE;
            tick_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // Strobes are single-cycle: they only stay high if re-asserted.
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                RX_IDLE: begin
                    if (enable && (rx_s != UART_IDLE_LEVEL)) begin
                        state_q <= RX_START;
                        tick_q  <= '0;
                    end
                end

                RX_START: begin
                    if (enable) begin
                        if (tick_q == TICK_MID) begin
                            tick_q <= '0;
                            if (rx_s == UART_IDLE_LEVEL) begin
                                // Line went back high before mid start bit:
                                // treat it as noise.
                                state_q <= RX_IDLE;
                            end else begin
                                state_q   <= RX_DATA;
                                bit_cnt_q <= '0;
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                end

                RX_DATA: begin
                    if (enable) begin
                        // A full bit period after the previous sample point
                        // keeps every sample near the middle of its bit.
                        if (tick_q == TICK_LAST) begin
                            tick_q    <= '0;
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            if (bit_cnt_q == BIT_LAST) begin
                                state_q <= RX_STOP;
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                end

                RX_STOP: begin
                    if (enable) begin
                        if (tick_q == TICK_LAST) begin
                            tick_q <= '0;
                            if (rx_s == UART_IDLE_LEVEL) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                                state_q <= RX_IDLE;
                            end else begin
                                // data_q keeps the last good word.
                                frame_err_q <= 1'b1;
                                state_q     <= RX_BREAK;
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                end

                RX_BREAK: begin
                    // Wait for the line to return to idle so that a line held
                    // low is not decoded as an endless run of start bits.
                    // No tick needed: leave as soon as the line is high.
                    if (rx_s == UART_IDLE_LEVEL) begin
                        state_q <= RX_IDLE;
                    end
                end

                default: begin
                    state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != RX_IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. A serial line driver produces frames with
// clk-exact bit periods of OVERSAMPLE * enable-period. A monitor records every
// valid / frame_err pulse; each test compares the recorded pulses against the
// outcome expected from the frame contents alone (good stop bit -> byte
// delivered, bad stop bit -> error with the previous byte retained).
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int OS = 16;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       rx_in;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int en_period = 4;
    int both_cnt  = 0;
    logic [7:0] model_data = 8'h00;

    typedef struct packed {
        logic       is_err;
        logic [7:0] d;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in        (rx_in),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample tick: one clk high every en_period clks.
    initial begin
        int cnt;
        cnt = 0;
        enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cnt >= en_period - 1) cnt = 0;
            else cnt = cnt + 1;
            enable = (cnt == 0);
        end
    end

    // Monitor: one line per received transaction.
    initial begin
        forever begin
            @(negedge clk);
            if (valid === 1'b1 && frame_err === 1'b1) both_cnt = both_cnt + 1;
            if (valid === 1'b1) begin
                obs_q.push_back({1'b0, data});
                $display("rx valid     data=%02h t=%0t", data, $time);
            end
            if (frame_err === 1'b1) begin
                obs_q.push_back({1'b1, data});
                $display("rx frame_err data=%02h t=%0t", data, $time);
            end
        end
    end

    // Wait n clks, ending 1 time unit after the last posedge.
    task automatic clks(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic line_bit(input logic v);
        rx_in = v;
        clks(OS * en_period);
    endtask

    // Drive one 8N1 frame and record the outcome it should produce.
    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
        line_bit(stop_v);
        if (stop_v) begin
            exp_q.push_back({1'b0, b});
            model_data = b;
        end else begin
            exp_q.push_back({1'b1, model_data});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_in = 1'b1;
        en_period = 4;
        model_data = 8'h00;
        clks(5);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%02h want=00", data); end
        rst_n = 1'b1;
        clks(8);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_single_byte();
        en_period = 4;
        send_frame(8'hA5, 1'b1);
        rx_in = 1'b1;
        clks(4);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy); end
        total++; if (data !== 8'hA5) begin bad++; $display("FAIL single_data got=%02h want=a5", data); end
        for (int k = 0; k < 3; k++) begin
            clks($urandom_range(1, 40));
            send_frame(8'($urandom), 1'b1);
        end
        rx_in = 1'b1;
        clks(4);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL single_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_ev%0d got=%b/%02h want=%b/%02h", i, obs_q[i].is_err, obs_q[i].d, exp_q[i].is_err, exp_q[i].d); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch();
        en_period = 4;
        for (int k = 0; k < 3; k++) begin
            int len;
            len = (k == 0) ? 4 : int'($urandom_range(1, 5));
            rx_in = 1'b0;
            clks(len * en_period);
            rx_in = 1'b1;
            clks(12 * en_period);
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy len=%0d got=%b want=0", len, busy); end
        end
        send_frame(8'h3C, 1'b1);
        send_frame(8'($urandom), 1'b1);
        rx_in = 1'b1;
        clks(4);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL glitch_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL glitch_ev%0d got=%b/%02h want=%b/%02h", i, obs_q[i].is_err, obs_q[i].d, exp_q[i].is_err, exp_q[i].d); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_break();
        en_period = int'($urandom_range(2, 4));
        send_frame(8'($urandom), 1'b1);
        send_frame(8'h55, 1'b0);
        clks(40 * en_period);              // line still held low
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy_hold got=%b want=1", busy); end
        total++; if (data !== model_data) begin bad++; $display("FAIL break_data_kept got=%02h want=%02h", data, model_data); end
        rx_in = 1'b1;
        clks(4);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_release_busy got=%b want=0", busy); end
        clks(OS * en_period);
        send_frame(8'h81, 1'b1);
        rx_in = 1'b1;
        clks(4);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL break_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL break_ev%0d got=%b/%02h want=%b/%02h", i, obs_q[i].is_err, obs_q[i].d, exp_q[i].is_err, exp_q[i].d); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        en_period = 4;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        for (int k = 0; k < 4; k++) send_frame(8'($urandom), 1'b1);
        rx_in = 1'b1;
        clks(8);
        total++; if (data !== model_data) begin bad++; $display("FAIL b2b_data got=%02h want=%02h", data, model_data); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_ev%0d got=%b/%02h want=%b/%02h", i, obs_q[i].is_err, obs_q[i].d, exp_q[i].is_err, exp_q[i].d); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] partial;
        partial = 8'hC3;
        en_period = 4;
        send_frame(8'($urandom) | 8'h01, 1'b1);   // make data non-zero
        line_bit(1'b0);
        for (int i = 0; i < 4; i++) line_bit(partial[i]);
        rx_in = partial[4];
        clks(OS * en_period / 2);                 // middle of data bit 4
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
        rst_n = 1'b0;
        #2;                                       // no clk edge yet
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_async_busy got=%b want=0", busy); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL midrst_async_data got=%02h want=00", data); end
        rx_in = 1'b1;
        model_data = 8'h00;
        clks(3);
        rst_n = 1'b1;
        clks(2 * OS * en_period);
        send_frame(8'h12, 1'b1);
        rx_in = 1'b1;
        clks(4);
        total++; if (data !== 8'h12) begin bad++; $display("FAIL midrst_data got=%02h want=12", data); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL midrst_ev%0d got=%b/%02h want=%b/%02h", i, obs_q[i].is_err, obs_q[i].d, exp_q[i].is_err, exp_q[i].d); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            logic good;
            en_period = int'($urandom_range(1, 4));
            good = ($urandom_range(0, 3) != 0);
            send_frame(8'($urandom), good);
            if (!good) begin
                clks(int'($urandom_range(0, 20)) * en_period);
                rx_in = 1'b1;
                clks(4 + int'($urandom_range(0, 8)));
            end else begin
                rx_in = 1'b1;
                clks(int'($urandom_range(0, 3)) * en_period);
            end
        end
        rx_in = 1'b1;
        clks(8);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_busy got=%b want=0", busy); end
        total++; if (data !== model_data) begin bad++; $display("FAIL rand_data got=%02h want=%02h", data, model_data); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_ev%0d got=%b/%02h want=%b/%02h", i, obs_q[i].is_err, obs_q[i].d, exp_q[i].is_err, exp_q[i].d); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    // Transmitter-style stream: every byte value in order, no idle between.
    task automatic test_loopback();
        en_period = 1;
        clks(OS);
        for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1);
        rx_in = 1'b1;
        clks(8);
        total++; if (obs_q.size() != 256) begin bad++; $display("FAIL loop_count got=%0d want=256", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL loop_ev%0d got=%b/%02h want=%b/%02h", i, obs_q[i].is_err, obs_q[i].d, exp_q[i].is_err, exp_q[i].d); end
        end
        obs_q.delete(); exp_q.delete();
        total++; if (both_cnt != 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", both_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        rx_in = 1'b1;
        test_reset();
        test_single_byte();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx
